// File: rtl/rcon_gen.sv
// rcon_gen: writes the AES key-schedule Rcon words into the 8-bit-addressed
// Rcon store, one word per handshake beat, generating each constant with a
// GF(2^8) doubling step instead of a hard-coded table.
module rcon_gen #(
  parameter int DEPTH = 64,  // words per run, 1..256
  parameter int BITS  = 32   // word width, >= 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            ready,
  output logic            we,
  output logic [7:0]      address1,
  output logic [BITS-1:0] writeData,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);

  // GF(2^8) multiply-by-two with the AES reduction polynomial; stays 8 bits.
  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // Place the round constant in the top byte, zeros below.
  function automatic logic [BITS-1:0] word_of(input logic [7:0] v);
    logic [BITS-1:0] w;
    w = '0;
    w[BITS-1 -: 8] = v;
    return w;
  endfunction

  state_t          state, state_nx;
  logic [7:0]      idx, idx_nx;
  logic [7:0]      rc, rc_nx;
  logic            we_nx;
  logic            busy_nx;
  logic            done_nx;
  logic [7:0]      address_nx;
  logic [BITS-1:0] data_nx;

  // State, counters and all outputs are registered; reset restores IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 8'h00;
      rc        <= 8'h01;
      we        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      address1  <= 8'h00;
      writeData <= '0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      rc        <= rc_nx;
      we        <= we_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      address1  <= address_nx;
      writeData <= data_nx;
    end
  end

  // Next-state logic: advance the address and constant on each accepted beat.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    rc_nx    = rc;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = WRITE;
          idx_nx   = 8'h00;
          rc_nx    = 8'h01;
        end else begin
          state_nx = IDLE;
        end
      end
      WRITE: begin
        // we is always high in WRITE, so ready alone accepts the beat.
        if (ready) begin
          if (idx == LAST_IDX) begin
            state_nx = DONE;
          end else begin
            idx_nx = idx + 8'd1;
            rc_nx  = xtime(rc);
          end
        end else begin
          state_nx = WRITE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Output logic: next-cycle output values derived from the next state so
  // the registered outputs line up with the state they describe. Address and
  // data hold their last values outside WRITE.
  always_comb begin
    we_nx      = (state_nx == WRITE);
    busy_nx    = (state_nx == WRITE);
    done_nx    = (state_nx == DONE);
    address_nx = address1;
    data_nx    = writeData;
    if (state_nx == WRITE) begin
      address_nx = idx_nx;
      data_nx    = word_of(rc_nx);
    end else begin
      address_nx = address1;
      data_nx    = writeData;
    end
  end

endmodule

// File: tb/tb_rcon_gen.sv
// Self-checking bench for rcon_gen: DEPTH=64 runs with and without
// backpressure, mid-run reset, ignored start pulses, and a DEPTH=1 instance.
module tb_rcon_gen;

  localparam int D64 = 64;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, ready;
  logic        we, busy, done;
  logic [7:0]  address1;
  logic [31:0] writeData;

  logic        start1, ready1;
  logic        we1, busy1, done1;
  logic [7:0]  address1_1;
  logic [31:0] writeData1;

  int          n_tests = 0;
  int          n_fail  = 0;
  beat_t       exp_q[$];
  logic [31:0] mem [0:255];
  vec_t        tbl [10];

  always #5 clk = ~clk;

  rcon_gen #(.DEPTH(D64), .BITS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .we(we), .address1(address1), .writeData(writeData),
    .busy(busy), .done(done)
  );

  rcon_gen #(.DEPTH(1), .BITS(32)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .ready(ready1),
    .we(we1), .address1(address1_1), .writeData(writeData1),
    .busy(busy1), .done(done1)
  );

  function automatic logic [7:0] ref_xtime(input logic [7:0] v);
    logic [8:0] s;
    s = {v, 1'b0};
    if (s[8]) s = s ^ 9'h11b;
    return s[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One full DEPTH=64 run starting from an IDLE observation point.
  task automatic run(input bit bp, input bit poke);
    beat_t       e;
    int          beats = 0;
    int          cyc = 0;
    bit          fin = 1'b0;
    bit          stl = 1'b0;
    logic [7:0]  sa = 8'h00;
    logic [31:0] sd = 32'h0;
    logic [7:0]  r = 8'h01;
    for (int i = 0; i < D64; i++) begin
      exp_q.push_back('{addr: 8'(i), data: {r, 24'h000000}});
      r = ref_xtime(r);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!fin && cyc < 1000) begin
      if (beats == D64) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_we", 32'(we), 32'd0);
        fin = 1'b1;
      end else begin
        chk("we_in_write", 32'(we), 32'd1);
        chk("busy_in_write", 32'(busy), 32'd1);
        chk("done_early", 32'(done), 32'd0);
        if (stl) begin
          chk("stall_addr", 32'(address1), 32'(sa));
          chk("stall_data", writeData, sd);
        end
        ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (poke) start = 1'($urandom_range(0, 1));
        if (we && ready) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("beat_addr_%0d", beats), 32'(address1), 32'(e.addr));
            chk($sformatf("beat_data_%0d", beats), writeData, e.data);
            mem[address1] = writeData;
          end
          beats++;
        end
        stl = we && !ready;
        sa  = address1;
        sd  = writeData;
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("run_finished", 32'(fin), 32'd1);
    // A start during DONE must be dropped.
    start = poke;
    @(posedge clk); #1;
    start = 1'b0;
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_we", 32'(we), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("no_second_run", 32'(we), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    tbl[0] = '{8'd0,  32'h01000000};
    tbl[1] = '{8'd7,  32'h80000000};
    tbl[2] = '{8'd8,  32'h1b000000};
    tbl[3] = '{8'd9,  32'h36000000};
    tbl[4] = '{8'd10, 32'h6c000000};
    tbl[5] = '{8'd11, 32'hd8000000};
    tbl[6] = '{8'd12, 32'hab000000};
    tbl[7] = '{8'd50, 32'h8d000000};
    tbl[8] = '{8'd51, 32'h01000000};
    tbl[9] = '{8'd63, 32'hab000000};
    for (int i = 0; i < 256; i++) mem[i] = 32'hdeadbeef;

    rst = 1'b1; start = 1'b0; ready = 1'b0; start1 = 1'b0; ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", 32'(address1), 32'd0);
    chk("rst_data", writeData, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we_d1", 32'(we1), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full run, ready held high, then the known-value table.
    run(1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      chk($sformatf("tbl_addr_%0d", tbl[i].addr), mem[tbl[i].addr], tbl[i].data);

    // Random backpressure.
    run(1'b1, 1'b0);

    // Reset while the beat at address 5 is presented.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 20 && address1 != 8'h05; i++) begin
      @(posedge clk); #1;
    end
    chk("reach_addr5", 32'(address1), 32'h05);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_we", 32'(we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_addr", 32'(address1), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    run(1'b0, 1'b0);

    // Start pulses during WRITE and DONE are ignored.
    run(1'b0, 1'b1);

    // DEPTH=1 instance.
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("d1_we", 32'(we1), 32'd1);
    chk("d1_busy", 32'(busy1), 32'd1);
    chk("d1_addr", 32'(address1_1), 32'd0);
    chk("d1_data", writeData1, 32'h01000000);
    @(posedge clk); #1;
    chk("d1_done", 32'(done1), 32'd1);
    chk("d1_done_we", 32'(we1), 32'd0);
    chk("d1_done_busy", 32'(busy1), 32'd0);
    @(posedge clk); #1;
    chk("d1_idle_done", 32'(done1), 32'd0);
    chk("d1_idle_we", 32'(we1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rcon_gen.md
# rcon_gen

Sequential round-constant generator that produces the AES key-schedule Rcon words on the fly and writes them, one per handshake beat, into the 8-bit-addressed Rcon word store read by the `rcon` lookup block. It replaces a hard-coded initialisation with a GF(2^8) doubling engine, so the table contents are regenerated after every reset or on demand. It is the writer end of the `address1`/data interface whose read end is `rcon`.

## Interface
- DEPTH, 64, number of words written per run; legal range 1..256 because the address is 8 bits.
- BITS, 32, word width; must be at least 8.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- ready  in  1  store accepts the current beat.
- we  out  1  beat valid / write enable.
- address1  out  8  word address of the current beat.
- writeData  out  BITS  Rcon word: {rc, (BITS-8)'b0}.
- busy  out  1  high in WRITE.
- done  out  1  one-cycle pulse after the last beat.

## Operation
- FSM states: IDLE, WRITE, DONE.
  - IDLE -> WRITE when start=1. Load rc=8'h01 and idx=0.
  - WRITE: drive we=1, address1=idx, writeData={rc,0}.
    - On a beat with we&&ready and idx<DEPTH-1: idx<=idx+1 and rc<=xtime(rc).
    - On a beat with idx==DEPTH-1: go to DONE.
  - DONE: done=1 for one cycle, then IDLE unconditionally.
- xtime(rc) = {rc[6:0],1'b0} ^ (rc[7] ? 8'h1b : 8'h00). It is 8-bit modular and never widens.
- Contents, one value per address: address i holds rc_(i+1).
  - Addresses 0..9: 01,02,04,08,10,20,40,80,1b,36.
  - Address 10 holds 6c. Address 11 holds d8.
  - The sequence continues to address DEPTH-1 with no wrap or restart.
- Outputs are registered; the combinational path from ready to the outputs is limited to next-state logic.
- Holding rule: while we=1 and ready=0, address1 and writeData are held stable and we stays high.
- start is ignored in WRITE and DONE. No queuing; a start seen in DONE is dropped.
- Reset mid-run: all state is cleared on the next edge and the FSM goes to IDLE. Beats already written are not retracted. A later start begins again at address 0 with rc=01.
- DEPTH=1: a single beat (address 0, data 01 followed by zeros), then DONE.

## Timing
- Reset values: we=0, address1=8'h00, writeData=0, busy=0, done=0. The FSM is in IDLE with rc=01 and idx=0.
- With start high at edge N, the first beat is visible after edge N; we=1 and busy=1 from the cycle after N.
- Throughput: one beat per cycle when ready is held high. A full run takes DEPTH WRITE cycles plus 1 DONE cycle.
- After the last beat is accepted at edge M, the cycle after M has done=1, busy=0 and we=0. The cycle after that is IDLE with done=0.
- Start-to-start latency with ready=1: DEPTH+2 cycles. The earliest restart is start sampled during the IDLE cycle that follows DONE.
- In IDLE, address1 and writeData hold their last driven values; consumers must qualify them with we.

## Test plan
- Reset then start pulse, ready=1, DEPTH=64 -> 64 consecutive beats.
  - Addresses 00..3f.
  - writeData at addresses 0, 7, 8, 9 = 01000000, 80000000, 1b000000, 36000000.
  - done high exactly 1 cycle after address 3f; busy low during it.
- Scoreboard the full run -> every address i matches an xtime reference model (address 50 = 8d000000), with no duplicate or skipped address.
- Random ready backpressure (about 50% low) -> same 64 words in order; address1 and writeData stable across every ready=0 stall; done still a single pulse.
- rst asserted at beat address 0x05 -> the next cycle has we=0, busy=0, address1=00. A new start produces address 00 with data 01000000.
- start pulsed during WRITE and during DONE -> no effect on sequence or timing; FSM is in IDLE afterwards with no second run.
- DEPTH=1 instance, start -> one beat (address 00, data 01000000), done on the next cycle.
